// File: rtl/mlp_pkg.sv
// Shared types and requantisation helper for the MLP datapath.
package mlp_pkg;

  localparam int OutFifoDepth = 2;
  localparam int RsW          = 64;

  typedef struct packed {
    logic signed [RsW-1:0] data;
    logic                  sat;
  } rs_t;

  // Round-half-up, arithmetic shift, then clamp to a signed nbits_out range.
  // Callers truncate the packed {data, sat} result to {data[nbits_out-1:0], sat}.
  function automatic logic [RsW:0] round_sat(input logic signed [RsW-1:0] value,
                                             input int shift, input int nbits_out);
    logic signed [RsW-1:0] t, hi, lo;
    rs_t r;
    t = value;
    if (shift > 0) t = value + (64'sd1 <<< (shift - 1));
    t  = t >>> shift;
    hi = (64'sd1 <<< (nbits_out - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    r.sat = 1'b1;
    if (t > hi)      r.data = hi;
    else if (t < lo) r.data = lo;
    else begin
      r.data = t;
      r.sat  = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo2.sv
// Two-entry registered FIFO; push side never stalls, occupancy is bounded upstream.
module fifo2
  import mlp_pkg::*;
#(
  parameter int Width = 9
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [Width-1:0] pop_data
);

  logic [Width-1:0] mem [OutFifoDepth];
  logic             wr_ptr, rd_ptr;
  logic [1:0]       count;
  logic             pop;

  assign pop_valid = (count != 2'd0);
  assign pop       = pop_valid & pop_ready;
  assign pop_data  = mem[rd_ptr];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < OutFifoDepth; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/addertree_accum.sv
// Accumulates adder-tree chunk sums into a dot product, adds bias, requantises,
// and throttles chunk issue so at most two results are ever outstanding.
module addertree_accum
  import mlp_pkg::*;
#(
  parameter int NBitsSum    = 16,
  parameter int NBitsAcc    = 32,
  parameter int NBitsOut    = 8,
  parameter int TreeLatency = 3,
  parameter int Shift       = 8
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       chunk_valid_in,
  input  logic                       chunk_last_in,
  output logic                       chunk_ready_out,
  input  logic signed [NBitsSum-1:0] sum_in,
  input  logic signed [NBitsAcc-1:0] bias_in,
  output logic signed [NBitsOut-1:0] out_data,
  output logic                       out_sat,
  output logic                       out_valid,
  input  logic                       out_ready_in
);

  logic                       acc_ev, last_ev, pop;
  logic [1:0]                 outstanding;
  logic [TreeLatency-1:0]     vld_pipe, last_pipe;
  logic                       d_valid, d_last;
  logic signed [NBitsAcc-1:0] s_ext, acc, r_q;
  logic                       r_vld;
  logic [NBitsOut:0]          push_data, pop_data;

  assign chunk_ready_out = (outstanding < 2'd2);
  assign acc_ev          = chunk_valid_in & chunk_ready_out;
  assign last_ev         = acc_ev & chunk_last_in;
  assign pop             = out_valid & out_ready_in;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) outstanding <= 2'd0;
    else           outstanding <= outstanding + 2'(last_ev) - 2'(pop);
  end

  // The tree carries no valid, so its latency is mirrored here.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      vld_pipe[0]  <= acc_ev;
      last_pipe[0] <= last_ev;
      for (int i = 1; i < TreeLatency; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
      end
    end
  end

  assign d_valid = vld_pipe[TreeLatency-1];
  assign d_last  = last_pipe[TreeLatency-1];
  assign s_ext   = NBitsAcc'(sum_in);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      acc   <= '0;
      r_q   <= '0;
      r_vld <= 1'b0;
    end else begin
      r_vld <= d_valid & d_last;
      if (d_valid) begin
        if (d_last) begin
          r_q <= acc + s_ext + bias_in;
          acc <= '0;
        end else begin
          acc <= acc + s_ext;
        end
      end
    end
  end

  assign push_data = (NBitsOut+1)'(round_sat(RsW'(r_q), Shift, NBitsOut));

  fifo2 #(.Width(NBitsOut+1)) u_fifo (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .push      (r_vld),
    .push_data (push_data),
    .pop_valid (out_valid),
    .pop_ready (out_ready_in),
    .pop_data  (pop_data)
  );

  assign out_data = pop_data[NBitsOut:1];
  assign out_sat  = pop_data[0];

endmodule
